// File: rtl/msdap_pkg.sv
// Shared types and constants for the multi-channel MSDAP controller.
// Holds the controller state encoding, default sizing and the address-width helper.
package msdap_pkg;

  typedef enum logic [3:0] {
    STARTUP,
    WAIT_RJ,
    READ_RJ,
    WAIT_COEFF,
    READ_COEFF,
    WAIT_INPUT,
    COMPUTE,
    CLEAR,
    SLEEP
  } msdap_state_e;

  localparam int unsigned DEF_NCH          = 2;
  localparam int unsigned DEF_RJ_DEPTH     = 16;
  localparam int unsigned DEF_COEFF_DEPTH  = 512;
  localparam int unsigned DEF_DATA_DEPTH   = 256;
  localparam int unsigned DEF_SLEEP_THRESH = 800;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    int unsigned w;
    w = (n <= 1) ? 1 : $clog2(n);
    return w;
  endfunction

endpackage

// File: rtl/msdap_zero_run_counter.sv
// Saturating count of consecutive all-zero input frames.
// Clear wins over increment; at_thresh is high once the count reaches THRESH.
module msdap_zero_run_counter
  import msdap_pkg::*;
#(
  parameter int unsigned THRESH = DEF_SLEEP_THRESH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_thresh
);

  localparam int unsigned W = addr_w(THRESH + 1);
  localparam logic [W-1:0] MAX = W'(THRESH);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_thresh = (cnt_q == MAX);

endmodule

// File: rtl/msdap_multich_controller.sv
// Top-level MSDAP controller for NCH filter channels: power-up wipe, rj/coeff
// table loading, circular sample writes, compute sequencing, soft clear and sleep.
module msdap_multich_controller
  import msdap_pkg::*;
#(
  parameter int unsigned NCH          = DEF_NCH,
  parameter int unsigned RJ_DEPTH     = DEF_RJ_DEPTH,
  parameter int unsigned COEFF_DEPTH  = DEF_COEFF_DEPTH,
  parameter int unsigned DATA_DEPTH   = DEF_DATA_DEPTH,
  parameter int unsigned SLEEP_THRESH = DEF_SLEEP_THRESH
) (
  input  logic                           Sclk,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic                           Soft_clear,
  input  logic                           input_rdy_flag,
  input  logic [NCH-1:0]                 zero_flag,
  input  logic [NCH-1:0]                 compute_done,
  output logic [addr_w(NCH)-1:0]         ch_wr_sel,
  output logic [addr_w(RJ_DEPTH)-1:0]    rj_wr_addr,
  output logic [addr_w(COEFF_DEPTH)-1:0] coeff_wr_addr,
  output logic [addr_w(DATA_DEPTH)-1:0]  data_wr_addr,
  output logic                           rj_en,
  output logic                           coeff_en,
  output logic                           data_en,
  output logic                           Clear,
  output logic [NCH-1:0]                 compute_enable,
  output logic                           sleep_flag,
  output logic                           InReady,
  output logic                           overrun
);

  localparam int unsigned CW = addr_w(NCH);
  localparam int unsigned RW = addr_w(RJ_DEPTH);
  localparam int unsigned KW = addr_w(COEFF_DEPTH);
  localparam int unsigned DW = addr_w(DATA_DEPTH);

  localparam logic [CW-1:0] CH_LAST    = CW'(NCH - 1);
  localparam logic [RW-1:0] RJ_LAST    = RW'(RJ_DEPTH - 1);
  localparam logic [KW-1:0] COEFF_LAST = KW'(COEFF_DEPTH - 1);
  localparam logic [DW-1:0] DATA_LAST  = DW'(DATA_DEPTH - 1);

  msdap_state_e   state_q, state_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [RW-1:0]  rj_addr_q, rj_addr_d;
  logic [KW-1:0]  coeff_addr_q, coeff_addr_d;
  logic [DW-1:0]  data_addr_q, data_addr_d;
  logic           rj_en_q, rj_en_d;
  logic           coeff_en_q, coeff_en_d;
  logic           data_en_q, data_en_d;
  logic           data_adv_q, data_adv_d;
  logic           clear_q, clear_d;
  logic [NCH-1:0] cen_q, cen_d;
  logic [NCH-1:0] done_q, done_d;
  logic           sleep_q, sleep_d;
  logic           inready_q, inready_d;
  logic           overrun_q, overrun_d;
  logic           soft_q, soft_d;

  logic [NCH-1:0] done_next;
  logic           go_clear, clear_soft, do_write;
  logic           zc_inc, zc_clr, zc_at;

  msdap_zero_run_counter #(
    .THRESH (SLEEP_THRESH)
  ) u_zero_run (
    .clk       (Sclk),
    .rst       (Reset),
    .clr       (zc_clr),
    .inc       (zc_inc),
    .at_thresh (zc_at)
  );

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    rj_addr_d    = rj_addr_q;
    coeff_addr_d = coeff_addr_q;
    data_addr_d  = data_addr_q;
    rj_en_d      = 1'b0;
    coeff_en_d   = 1'b0;
    data_en_d    = 1'b0;
    data_adv_d   = 1'b0;
    clear_d      = 1'b0;
    cen_d        = '0;
    done_d       = done_q;
    sleep_d      = sleep_q;
    inready_d    = inready_q;
    overrun_d    = overrun_q;
    soft_d       = soft_q;
    zc_inc       = 1'b0;
    zc_clr       = 1'b0;
    go_clear     = 1'b0;
    clear_soft   = 1'b0;
    do_write     = 1'b0;
    // A done arriving alongside this channel's start pulse belongs to an older run.
    done_next    = done_q | (compute_done & ~cen_q);

    // Addresses step one cycle after their strobe, so the strobe cycle shows
    // the word being written; the _d values below are the next write target.
    if (rj_en_q) begin
      if (rj_addr_q == RJ_LAST) begin
        rj_addr_d = '0;
        ch_d      = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end else begin
        rj_addr_d = rj_addr_q + 1'b1;
      end
    end
    if (coeff_en_q) begin
      if (coeff_addr_q == COEFF_LAST) begin
        coeff_addr_d = '0;
        ch_d         = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end else begin
        coeff_addr_d = coeff_addr_q + 1'b1;
      end
    end
    if (data_adv_q) begin
      data_addr_d = (data_addr_q == DATA_LAST) ? '0 : data_addr_q + 1'b1;
    end

    case (state_q)
      STARTUP: begin
        if (!Start) go_clear = 1'b1;
      end
      CLEAR: begin
        zc_clr = 1'b1;
        if (data_addr_q == DATA_LAST) begin
          data_addr_d = '0;
          inready_d   = 1'b1;
          state_d     = soft_q ? WAIT_INPUT : WAIT_RJ;
        end else begin
          data_addr_d = data_addr_q + 1'b1;
          clear_d     = 1'b1;
          data_en_d   = 1'b1;
        end
      end
      WAIT_RJ, READ_RJ: begin
        if (input_rdy_flag) begin
          rj_en_d = 1'b1;
          state_d = (rj_addr_d == RJ_LAST && ch_d == CH_LAST) ? WAIT_COEFF : READ_RJ;
        end
      end
      WAIT_COEFF, READ_COEFF: begin
        if (input_rdy_flag) begin
          coeff_en_d = 1'b1;
          state_d = (coeff_addr_d == COEFF_LAST && ch_d == CH_LAST) ? WAIT_INPUT : READ_COEFF;
        end
      end
      WAIT_INPUT: begin
        if (Soft_clear) begin
          go_clear   = 1'b1;
          clear_soft = 1'b1;
        end else if (input_rdy_flag) begin
          do_write = 1'b1;
          cen_d    = '1;
          done_d   = '0;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        if (Soft_clear) begin
          go_clear   = 1'b1;
          clear_soft = 1'b1;
        end else if (input_rdy_flag) begin
          // New sample while busy: keep it, flag overrun, retry completion next cycle.
          do_write  = 1'b1;
          overrun_d = 1'b1;
          done_d    = done_next;
        end else if (&done_next) begin
          done_d  = '0;
          sleep_d = zc_at;
          state_d = zc_at ? SLEEP : WAIT_INPUT;
        end else begin
          done_d = done_next;
        end
      end
      SLEEP: begin
        if (Soft_clear) begin
          go_clear   = 1'b1;
          clear_soft = 1'b1;
        end else if (input_rdy_flag) begin
          do_write = 1'b1;
          if (!(&zero_flag)) begin
            cen_d   = '1;
            done_d  = '0;
            sleep_d = 1'b0;
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = STARTUP;
    endcase

    if (do_write) begin
      data_en_d  = 1'b1;
      data_adv_d = 1'b1;
      if (&zero_flag) zc_inc = 1'b1;
      else            zc_clr = 1'b1;
    end

    if (go_clear) begin
      state_d     = CLEAR;
      clear_d     = 1'b1;
      data_en_d   = 1'b1;
      data_adv_d  = 1'b0;
      data_addr_d = '0;
      cen_d       = '0;
      done_d      = '0;
      inready_d   = 1'b0;
      sleep_d     = 1'b0;
      soft_d      = clear_soft;
      zc_clr      = 1'b1;
    end
  end

  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state_q      <= STARTUP;
      ch_q         <= '0;
      rj_addr_q    <= '0;
      coeff_addr_q <= '0;
      data_addr_q  <= '0;
      rj_en_q      <= 1'b0;
      coeff_en_q   <= 1'b0;
      data_en_q    <= 1'b0;
      data_adv_q   <= 1'b0;
      clear_q      <= 1'b0;
      cen_q        <= '0;
      done_q       <= '0;
      sleep_q      <= 1'b0;
      inready_q    <= 1'b0;
      overrun_q    <= 1'b0;
      soft_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      rj_addr_q    <= rj_addr_d;
      coeff_addr_q <= coeff_addr_d;
      data_addr_q  <= data_addr_d;
      rj_en_q      <= rj_en_d;
      coeff_en_q   <= coeff_en_d;
      data_en_q    <= data_en_d;
      data_adv_q   <= data_adv_d;
      clear_q      <= clear_d;
      cen_q        <= cen_d;
      done_q       <= done_d;
      sleep_q      <= sleep_d;
      inready_q    <= inready_d;
      overrun_q    <= overrun_d;
      soft_q       <= soft_d;
    end
  end

  assign ch_wr_sel      = ch_q;
  assign rj_wr_addr     = rj_addr_q;
  assign coeff_wr_addr  = coeff_addr_q;
  assign data_wr_addr   = data_addr_q;
  assign rj_en          = rj_en_q;
  assign coeff_en       = coeff_en_q;
  assign data_en        = data_en_q;
  assign Clear          = clear_q;
  assign compute_enable = cen_q;
  assign sleep_flag     = sleep_q;
  assign InReady        = inready_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_msdap_multich_controller.sv
// Directed bench for msdap_multich_controller with NCH=2, RJ=4, COEFF=8, DATA=8, THRESH=3.
// Inputs change and outputs are sampled on the falling edge of Sclk.
module tb_msdap_multich_controller;
  import msdap_pkg::*;

  logic       Sclk = 1'b0;
  logic       Reset, Start, Soft_clear, input_rdy_flag;
  logic [1:0] zero_flag, compute_done;
  logic       ch_wr_sel;
  logic [1:0] rj_wr_addr;
  logic [2:0] coeff_wr_addr, data_wr_addr;
  logic       rj_en, coeff_en, data_en, Clear, sleep_flag, InReady, overrun;
  logic [1:0] compute_enable;

  int tests = 0;
  int fails = 0;
  int exp_da = 0;

  always #5 Sclk = ~Sclk;

  msdap_multich_controller #(
    .NCH          (2),
    .RJ_DEPTH     (4),
    .COEFF_DEPTH  (8),
    .DATA_DEPTH   (8),
    .SLEEP_THRESH (3)
  ) dut (
    .Sclk           (Sclk),
    .Reset          (Reset),
    .Start          (Start),
    .Soft_clear     (Soft_clear),
    .input_rdy_flag (input_rdy_flag),
    .zero_flag      (zero_flag),
    .compute_done   (compute_done),
    .ch_wr_sel      (ch_wr_sel),
    .rj_wr_addr     (rj_wr_addr),
    .coeff_wr_addr  (coeff_wr_addr),
    .data_wr_addr   (data_wr_addr),
    .rj_en          (rj_en),
    .coeff_en       (coeff_en),
    .data_en        (data_en),
    .Clear          (Clear),
    .compute_enable (compute_enable),
    .sleep_flag     (sleep_flag),
    .InReady        (InReady),
    .overrun        (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_rdy(input logic [1:0] zf);
    @(negedge Sclk);
    input_rdy_flag = 1'b1;
    zero_flag      = zf;
    @(negedge Sclk);
    input_rdy_flag = 1'b0;
  endtask

  task automatic done_pulse(input logic [1:0] d);
    @(negedge Sclk);
    compute_done = d;
    @(negedge Sclk);
    compute_done = 2'b00;
  endtask

  task automatic wait_state(input msdap_state_e st, input int budget, input string tag);
    for (int n = 0; n < budget; n++) begin
      if (dut.state_q === st) break;
      @(negedge Sclk);
    end
    check(tag, 32'(dut.state_q), 32'(st));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 32'(dut.state_q), 32'(STARTUP));
    check({tag, "_addrs"}, {25'd0, ch_wr_sel, rj_wr_addr, coeff_wr_addr, data_wr_addr}, 32'd0);
    check({tag, "_strb"}, {26'd0, rj_en, coeff_en, data_en, Clear, compute_enable}, 32'd0);
    check({tag, "_flags"}, {29'd0, sleep_flag, InReady, overrun}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; Soft_clear = 1'b0; input_rdy_flag = 1'b0;
    zero_flag = 2'b00; compute_done = 2'b00;
    @(negedge Sclk);
    @(negedge Sclk);
    check_reset_values("reset");

    // Power-up: Start held, then released into the initial wipe.
    Reset = 1'b0; Start = 1'b1;
    @(negedge Sclk);
    @(negedge Sclk);
    check("start_hold", 32'(dut.state_q), 32'(STARTUP));
    check("start_inready", 32'(InReady), 32'd0);
    Start = 1'b0;
    @(negedge Sclk);
    for (int i = 0; i < 8; i++) begin
      check("pwr_clear", {30'd0, Clear, data_en}, 32'd3);
      check("pwr_clear_addr", 32'(data_wr_addr), 32'(i));
      check("pwr_clear_inready", 32'(InReady), 32'd0);
      @(negedge Sclk);
    end
    check("pwr_clear_end", {30'd0, Clear, InReady}, 32'd1);
    wait_state(WAIT_RJ, 4, "to_wait_rj");

    for (int i = 0; i < 8; i++) begin
      pulse_rdy(2'b00);
      check("rj_en", 32'(rj_en), 32'd1);
      check("rj_ch_addr", {29'd0, ch_wr_sel, rj_wr_addr}, 32'((i / 4) * 4 + (i % 4)));
    end
    check("to_wait_coeff", 32'(dut.state_q), 32'(WAIT_COEFF));
    for (int i = 0; i < 16; i++) begin
      pulse_rdy(2'b00);
      check("coeff_en", 32'(coeff_en), 32'd1);
      check("coeff_ch_addr", {28'd0, ch_wr_sel, coeff_wr_addr}, 32'((i / 8) * 8 + (i % 8)));
    end
    check("load_done_state", 32'(dut.state_q), 32'(WAIT_INPUT));
    check("load_done_inready", 32'(InReady), 32'd1);

    // Sample wrap with nonzero frames.
    for (int i = 0; i < 10; i++) begin
      pulse_rdy(2'b00);
      check("wrap_data_en", 32'(data_en), 32'd1);
      check("wrap_addr", 32'(data_wr_addr), 32'(exp_da));
      check("wrap_cen", 32'(compute_enable), 32'd3);
      exp_da = (exp_da + 1) % 8;
      if (i == 0) begin
        compute_done = 2'b11;
        @(negedge Sclk);
        compute_done = 2'b00;
        check("done_with_cen_ignored", 32'(dut.state_q), 32'(COMPUTE));
      end
      done_pulse(2'b11);
      check("wrap_back", 32'(dut.state_q), 32'(WAIT_INPUT));
    end
    check("wrap_overrun", 32'(overrun), 32'd0);

    // Overrun: new frame while only ch0 has finished.
    pulse_rdy(2'b01);
    exp_da = (exp_da + 1) % 8;
    done_pulse(2'b01);
    check("ovr_partial", 32'(dut.state_q), 32'(COMPUTE));
    pulse_rdy(2'b01);
    check("ovr_data_en", 32'(data_en), 32'd1);
    check("ovr_addr", 32'(data_wr_addr), 32'(exp_da));
    exp_da = (exp_da + 1) % 8;
    check("ovr_no_cen", 32'(compute_enable), 32'd0);
    check("ovr_flag", 32'(overrun), 32'd1);
    done_pulse(2'b10);
    check("ovr_back", 32'(dut.state_q), 32'(WAIT_INPUT));
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Sleep after three zero frames, then wake.
    for (int i = 0; i < 3; i++) begin
      pulse_rdy(2'b11);
      check("zero_cen", 32'(compute_enable), 32'd3);
      exp_da = (exp_da + 1) % 8;
      done_pulse(2'b11);
      check("zero_sleep", 32'(sleep_flag), (i == 2) ? 32'd1 : 32'd0);
    end
    check("sleep_state", 32'(dut.state_q), 32'(SLEEP));
    pulse_rdy(2'b11);
    check("sleep_write", {30'd0, data_en, sleep_flag}, 32'd3);
    check("sleep_addr", 32'(data_wr_addr), 32'(exp_da));
    exp_da = (exp_da + 1) % 8;
    check("sleep_no_cen", 32'(compute_enable), 32'd0);
    pulse_rdy(2'b10);
    check("wake_sleep", 32'(sleep_flag), 32'd0);
    check("wake_cen", 32'(compute_enable), 32'd3);
    check("wake_state", 32'(dut.state_q), 32'(COMPUTE));
    exp_da = (exp_da + 1) % 8;
    done_pulse(2'b11);
    check("wake_back", 32'(dut.state_q), 32'(WAIT_INPUT));
    check("wake_cnt", 32'(dut.u_zero_run.cnt_q), 32'd0);

    // Soft clear from SLEEP.
    for (int i = 0; i < 3; i++) begin
      pulse_rdy(2'b11);
      done_pulse(2'b11);
    end
    check("sleep2_state", 32'(dut.state_q), 32'(SLEEP));
    @(negedge Sclk);
    Soft_clear = 1'b1;
    @(negedge Sclk);
    Soft_clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("soft_clear", {30'd0, Clear, InReady}, 32'd2);
      check("soft_addr", 32'(data_wr_addr), 32'(i));
      check("soft_tables", {30'd0, rj_en, coeff_en}, 32'd0);
      @(negedge Sclk);
    end
    check("soft_end", {30'd0, Clear, InReady}, 32'd1);
    check("soft_state", 32'(dut.state_q), 32'(WAIT_INPUT));
    check("soft_cnt", 32'(dut.u_zero_run.cnt_q), 32'd0);
    check("soft_addr0", 32'(data_wr_addr), 32'd0);
    check("soft_sleep", 32'(sleep_flag), 32'd0);

    // Reset in the middle of a coefficient load.
    @(negedge Sclk);
    Reset = 1'b1; Start = 1'b1;
    @(negedge Sclk);
    Reset = 1'b0;
    @(negedge Sclk);
    Start = 1'b0;
    wait_state(WAIT_RJ, 20, "rst2_wait_rj");
    for (int i = 0; i < 8; i++) pulse_rdy(2'b00);
    for (int i = 0; i < 3; i++) pulse_rdy(2'b00);
    check("mid_coeff_state", 32'(dut.state_q), 32'(READ_COEFF));
    check("mid_coeff_addr", 32'(coeff_wr_addr), 32'd2);
    Reset = 1'b1;
    @(negedge Sclk);
    check_reset_values("mid_reset");
    Reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
